// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the write-back arbiter slice.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back requesters, the register file and the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid_i;
    logic              a_ready_o;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_data_i;
    logic              b_valid_i;
    logic              b_ready_o;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_data_i;
    logic              RegWrite_o;
    logic [ADDR_W-1:0] RDaddr_o;
    logic [DATA_W-1:0] RDdata_o;
    logic              starve_o;
    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [DATA_W-1:0] RSraw_i;
    logic [DATA_W-1:0] RTraw_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        input  RSaddr_i, RTaddr_i, RSraw_i, RTraw_i,
        output a_ready_o, b_ready_o, starve_o,
        output RegWrite_o, RDaddr_o, RDdata_o,
        output RSdata_o, RTdata_o
    );

    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        output RSaddr_i, RTaddr_i, RSraw_i, RTraw_i,
        input  a_ready_o, b_ready_o, starve_o,
        input  RegWrite_o, RDaddr_o, RDdata_o,
        input  RSdata_o, RTdata_o
    );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: A has fixed priority, B is forced after STARVE_LIMIT lost cycles.
// Optional read-port forwarding of the in-flight write is enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int DATA_W       = REG_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input logic                  clk_i,
    input logic                  rst_n_i,
    regfile_wb_arbiter_if.slave  bus
);

    logic [CNT_W-1:0]  wait_cnt;
    logic              starve;
    logic              a_ready;
    logic              b_ready;
    logic              a_acc;
    logic              b_acc;
    wb_req_t           a_req;
    wb_req_t           b_req;
    wb_req_t           win_req;

    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    assign a_req.addr = bus.a_addr_i;
    assign a_req.data = bus.a_data_i;
    assign b_req.addr = bus.b_addr_i;
    assign b_req.data = bus.b_data_i;

    // Stage 0: grant from live requests and the registered wait counter
    assign starve = (wait_cnt == CNT_W'(STARVE_LIMIT)) && bus.b_valid_i;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (starve) begin
            b_ready = 1'b1;
        end else if (bus.a_valid_i) begin
            a_ready = 1'b1;
        end else begin
            b_ready = bus.b_valid_i;
        end
    end

    assign a_acc   = bus.a_valid_i && a_ready;
    assign b_acc   = bus.b_valid_i && b_ready;
    assign win_req = a_acc ? a_req : b_req;

    assign bus.a_ready_o = a_ready;
    assign bus.b_ready_o = b_ready;
    assign bus.starve_o  = starve;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (bus.b_valid_i && !b_ready) begin
            if (wait_cnt != CNT_W'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Stage 1: registered write port; address 0 is accepted but never written
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else if (a_acc || b_acc) begin
            wr_vld_p1  <= (win_req.addr != REG_ZERO);
            wr_addr_p1 <= win_req.addr;
            wr_data_p1 <= win_req.data;
        end else begin
            wr_vld_p1  <= 1'b0;
        end
    end

    assign bus.RegWrite_o = wr_vld_p1;
    assign bus.RDaddr_o   = wr_addr_p1;
    assign bus.RDdata_o   = wr_data_p1;

`ifdef REGFILE_WB_BYPASS_EN
    function automatic logic [DATA_W-1:0] rd_fwd(
        input logic [ADDR_W-1:0] rd_addr,
        input logic [DATA_W-1:0] rd_raw,
        input logic              wr_vld,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        if (wr_vld && (rd_addr == wr_addr) && (rd_addr != REG_ZERO)) begin
            return wr_data;
        end
        return rd_raw;
    endfunction

    assign bus.RSdata_o = rd_fwd(bus.RSaddr_i, bus.RSraw_i, wr_vld_p1, wr_addr_p1, wr_data_p1);
    assign bus.RTdata_o = rd_fwd(bus.RTaddr_i, bus.RTraw_i, wr_vld_p1, wr_addr_p1, wr_data_p1);
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^{bus.RSaddr_i, bus.RTaddr_i};
    assign bus.RSdata_o   = bus.RSraw_i;
    assign bus.RTdata_o   = bus.RTraw_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Reference model: count of consecutive cycles B lost, and the last write issued
    int          m_lost;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_wb_arbiter #(
        .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT), .CNT_W(4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void exp_grant(output logic ea, output logic eb, output logic es);
        es = bus.b_valid_i && (m_lost >= LIMIT);
        ea = !es && bus.a_valid_i;
        eb = es || (!bus.a_valid_i && bus.b_valid_i);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic [31:0] raw);
`ifdef REGFILE_WB_BYPASS_EN
        if (m_we && ra == m_addr && ra != 5'd0) return m_data;
`endif
        return raw;
    endfunction

    task automatic set_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
        bus.a_valid_i = v; bus.a_addr_i = ad; bus.a_data_i = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
        bus.b_valid_i = v; bus.b_addr_i = ad; bus.b_data_i = d;
    endtask

    // Advance one clock edge and update the model from the requests seen at that edge
    task automatic tick();
        logic ea, eb, es;
        exp_grant(ea, eb, es);
        @(posedge clk);
        if (!rst_n) begin
            m_lost = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (ea) begin
                m_we = (bus.a_addr_i != 5'd0); m_addr = bus.a_addr_i; m_data = bus.a_data_i;
            end else if (eb) begin
                m_we = (bus.b_addr_i != 5'd0); m_addr = bus.b_addr_i; m_data = bus.b_data_i;
            end else begin
                m_we = 1'b0;
            end
            m_lost = (bus.b_valid_i && !eb) ? m_lost + 1 : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(1'b1, 5'd5, 32'hCAFE_0001);
        set_b(1'b0, '0, '0);
        bus.RSaddr_i = '0; bus.RTaddr_i = '0; bus.RSraw_i = '0; bus.RTraw_i = '0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (bus.RegWrite_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", bus.RegWrite_o); end
        total++;
        if (bus.RDaddr_o !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus.RDaddr_o); end
        total++;
        if (bus.RDdata_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", bus.RDdata_o); end
        total++;
        if (bus.a_ready_o !== 1'b1) begin bad++; $display("FAIL reset_a_ready got=%0h exp=1", bus.a_ready_o); end
        rst_n = 1'b1;
        set_a(1'b0, '0, '0);
        tick();
        @(negedge clk);
        total++;
        if (bus.RegWrite_o !== 1'b0) begin bad++; $display("FAIL reset_release_we got=%0h exp=0", bus.RegWrite_o); end
        tick();
    endtask

    task automatic test_a_only();
        set_a(1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        total++;
        if (bus.a_ready_o !== 1'b1) begin bad++; $display("FAIL a_only_ready got=%0h exp=1", bus.a_ready_o); end
        tick();
        set_a(1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (bus.RegWrite_o !== 1'b1) begin bad++; $display("FAIL a_only_we got=%0h exp=1", bus.RegWrite_o); end
        total++;
        if (bus.RDaddr_o !== 5'd5) begin bad++; $display("FAIL a_only_addr got=%0h exp=5", bus.RDaddr_o); end
        total++;
        if (bus.RDdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL a_only_data got=%0h exp=deadbeef", bus.RDdata_o); end
        tick();
    endtask

    task automatic test_collision();
        set_a(1'b1, 5'd3, 32'h11);
        set_b(1'b1, 5'd7, 32'h22);
        @(negedge clk);
        total++;
        if ({bus.a_ready_o, bus.b_ready_o} !== 2'b10) begin
            bad++; $display("FAIL coll_grant got=%b exp=10", {bus.a_ready_o, bus.b_ready_o});
        end
        tick();
        set_a(1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (bus.b_ready_o !== 1'b1) begin bad++; $display("FAIL coll_b_ready got=%0h exp=1", bus.b_ready_o); end
        total++;
        if ({bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o} !== {1'b1, 5'd3, 32'h11}) begin
            bad++; $display("FAIL coll_wr_a got=%0h/%0h/%0h exp=1/3/11", bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o);
        end
        tick();
        set_b(1'b0, '0, '0);
        @(negedge clk);
        total++;
        if ({bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o} !== {1'b1, 5'd7, 32'h22}) begin
            bad++; $display("FAIL coll_wr_b got=%0h/%0h/%0h exp=1/7/22", bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o);
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus.RegWrite_o, bus.RDaddr_o} !== {1'b0, 5'd7}) begin
            bad++; $display("FAIL coll_idle_hold got=%0h/%0h exp=0/7", bus.RegWrite_o, bus.RDaddr_o);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [4:0]  a_ad;
        logic [31:0] b_d;
        logic        exp_forced;
        a_ad = 5'd1;
        b_d  = 32'hB0B0_0000;
        set_a(1'b1, a_ad, {27'd0, a_ad});
        set_b(1'b1, 5'd20, b_d);
        for (int cyc = 0; cyc < 11; cyc++) begin
            exp_forced = (cyc == 4) || (cyc == 9);
            @(negedge clk);
            total++;
            if ({bus.starve_o, bus.b_ready_o, bus.a_ready_o} !== {exp_forced, exp_forced, !exp_forced}) begin
                bad++;
                $display("FAIL starve_c%0d got=%b exp=%b", cyc,
                         {bus.starve_o, bus.b_ready_o, bus.a_ready_o}, {exp_forced, exp_forced, !exp_forced});
            end
            if (cyc == 5) begin
                total++;
                if ({bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o} !== {1'b1, 5'd20, 32'hB0B0_0000}) begin
                    bad++; $display("FAIL starve_wr_b got=%0h/%0h/%0h exp=1/14/b0b00000",
                                    bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o);
                end
            end
            tick();
            if (exp_forced) begin
                b_d = b_d + 1;
                set_b(1'b1, 5'd20, b_d);
            end else begin
                a_ad = a_ad + 1;
                set_a(1'b1, a_ad, {27'd0, a_ad});
            end
        end
        set_a(1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (bus.b_ready_o !== 1'b1) begin bad++; $display("FAIL starve_drain got=%0h exp=1", bus.b_ready_o); end
        tick();
        set_b(1'b0, '0, '0);
        tick();
    endtask

    task automatic test_zero_reg();
        set_b(1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        total++;
        if (bus.b_ready_o !== 1'b1) begin bad++; $display("FAIL zero_ready got=%0h exp=1", bus.b_ready_o); end
        tick();
        set_b(1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (bus.RegWrite_o !== 1'b0) begin bad++; $display("FAIL zero_we got=%0h exp=0", bus.RegWrite_o); end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_rs, exp_rt;
`ifdef REGFILE_WB_BYPASS_EN
        exp_rs = 32'h1234; exp_rt = 32'h1234;
`else
        exp_rs = 32'h0;    exp_rt = 32'h55;
`endif
        set_a(1'b1, 5'd9, 32'h1234);
        tick();
        set_a(1'b0, '0, '0);
        bus.RSaddr_i = 5'd9; bus.RSraw_i = 32'h0;
        bus.RTaddr_i = 5'd9; bus.RTraw_i = 32'h55;
        @(negedge clk);
        total++;
        if (bus.RegWrite_o !== 1'b1) begin bad++; $display("FAIL byp_we got=%0h exp=1", bus.RegWrite_o); end
        total++;
        if (bus.RSdata_o !== exp_rs) begin bad++; $display("FAIL byp_rs got=%0h exp=%0h", bus.RSdata_o, exp_rs); end
        total++;
        if (bus.RTdata_o !== exp_rt) begin bad++; $display("FAIL byp_rt got=%0h exp=%0h", bus.RTdata_o, exp_rt); end
        tick();
        set_a(1'b1, 5'd0, 32'hABCD);
        tick();
        set_a(1'b0, '0, '0);
        bus.RSaddr_i = 5'd0; bus.RSraw_i = 32'h77;
        @(negedge clk);
        total++;
        if (bus.RSdata_o !== 32'h77) begin bad++; $display("FAIL byp_zero got=%0h exp=77", bus.RSdata_o); end
        tick();
    endtask

    task automatic test_random();
        logic ea, eb, es;
        logic [31:0] ers, ert;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.a_valid_i && ($urandom_range(0, 2) != 0))
                set_a(1'b1, 5'($urandom_range(0, 31)), $urandom);
            if (!bus.b_valid_i && ($urandom_range(0, 2) == 0))
                set_b(1'b1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            bus.RSaddr_i = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
            bus.RTaddr_i = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
            bus.RSraw_i  = $urandom;
            bus.RTraw_i  = $urandom;
            @(negedge clk);
            exp_grant(ea, eb, es);
            ers = exp_rd(bus.RSaddr_i, bus.RSraw_i);
            ert = exp_rd(bus.RTaddr_i, bus.RTraw_i);
            total++;
            if ({bus.a_ready_o, bus.b_ready_o, bus.starve_o} !== {ea, eb, es}) begin
                bad++; $display("FAIL rnd_grant c%0d got=%b exp=%b", cyc,
                                {bus.a_ready_o, bus.b_ready_o, bus.starve_o}, {ea, eb, es});
            end
            total++;
            if (bus.RegWrite_o !== m_we) begin
                bad++; $display("FAIL rnd_we c%0d got=%0h exp=%0h", cyc, bus.RegWrite_o, m_we);
            end
            total++;
            if ({bus.RDaddr_o, bus.RDdata_o} !== {m_addr, m_data}) begin
                bad++; $display("FAIL rnd_wr c%0d got=%0h/%0h exp=%0h/%0h", cyc,
                                bus.RDaddr_o, bus.RDdata_o, m_addr, m_data);
            end
            total++;
            if ({bus.RSdata_o, bus.RTdata_o} !== {ers, ert}) begin
                bad++; $display("FAIL rnd_rd c%0d got=%0h/%0h exp=%0h/%0h", cyc,
                                bus.RSdata_o, bus.RTdata_o, ers, ert);
            end
            tick();
            if (ea) set_a(1'b0, '0, '0);
            if (eb) set_b(1'b0, '0, '0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_lost = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        test_reset();
        test_a_only();
        test_collision();
        test_starvation();
        test_zero_reg();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
